// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multi-cycle RV32I sequencing controller: state codes,
// datapath mux codes, opcode constants and the bundled per-cycle control word.
package multicycle_control_fsm_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  localparam logic       ALU_A_PC  = 1'b0;
  localparam logic       ALU_A_RS1 = 1'b1;
  localparam logic [1:0] ALU_B_RS2 = 2'd0;
  localparam logic [1:0] ALU_B_IMM = 2'd1;

  localparam logic [1:0] ALU_OP_ADD    = 2'd0;
  localparam logic [1:0] ALU_OP_BRANCH = 2'd1;
  localparam logic [1:0] ALU_OP_FUNCT  = 2'd2;

  localparam logic [1:0] PC_SRC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_ALU    = 2'd2;

  localparam logic [6:0] OPC_ARITH     = 7'b0110011;
  localparam logic [6:0] OPC_ARITH_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       pc_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       is_ecall;
    logic       halted;
  } ctl_t;

  // Opcodes that proceed from decode into execute; anything else retires as a NOP.
  function automatic logic needs_execute(input logic [6:0] op);
    return op inside {OPC_ARITH, OPC_ARITH_IMM, OPC_LOAD, OPC_STORE,
                      OPC_BRANCH, OPC_JAL, OPC_JALR};
  endfunction

endpackage

// File: rtl/multicycle_control_fsm.sv
// Sequencing controller for the multi-cycle RV32I core: steps IF/ID/EX/MEM/WB over a
// shared memory and ALU, halts on the exit ecall and counts retired instructions.
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int          CNT_W     = 32,
  parameter logic [31:0] HALT_CODE = 32'd10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic [31:0]      rf17,
  input  logic             bcond,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             pc_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             pc_write,
  output logic [1:0]       pc_source,
  output logic             is_ecall,
  output logic             halted,
  output logic [CNT_W-1:0] retired_cnt
);

  state_t state;
  state_t state_next;
  ctl_t   ctl;
  ctl_t   ctl_out;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IF;
    else        state <= state_next;
  end

  // NOTE: ctl and state_next get defaults before the case, so no path can infer a latch.
  always_comb begin
    ctl        = '0;
    state_next = state;
    case (state)
      S_IF: begin
        ctl.mem_read = 1'b1;
        ctl.ir_write = mem_ready;
        if (mem_ready) state_next = S_ID;
      end
      S_ID: begin
        if (opcode == OPC_SYSTEM) begin
          ctl.is_ecall = 1'b1;
          if (rf17 == HALT_CODE) begin
            state_next = S_HALT;
          end else begin
            ctl.pc_write  = 1'b1;
            ctl.pc_source = PC_SRC_PLUS4;
            state_next    = S_IF;
          end
        end else if (needs_execute(opcode)) begin
          state_next = S_EX;
        end else begin
          ctl.pc_write  = 1'b1;
          ctl.pc_source = PC_SRC_PLUS4;
          state_next    = S_IF;
        end
      end
      S_EX: begin
        state_next = S_WB;
        case (opcode)
          OPC_ARITH: begin
            ctl.alu_src_a = ALU_A_RS1;
            ctl.alu_src_b = ALU_B_RS2;
            ctl.alu_op    = ALU_OP_FUNCT;
          end
          OPC_ARITH_IMM: begin
            ctl.alu_src_a = ALU_A_RS1;
            ctl.alu_src_b = ALU_B_IMM;
            ctl.alu_op    = ALU_OP_FUNCT;
          end
          OPC_LOAD, OPC_STORE: begin
            ctl.alu_src_a = ALU_A_RS1;
            ctl.alu_src_b = ALU_B_IMM;
            ctl.alu_op    = ALU_OP_ADD;
            state_next    = S_MEM;
          end
          OPC_BRANCH: begin
            // Taken/not-taken resolves in this same cycle, so pc_source follows bcond directly.
            ctl.alu_src_a = ALU_A_RS1;
            ctl.alu_src_b = ALU_B_RS2;
            ctl.alu_op    = ALU_OP_BRANCH;
            ctl.pc_write  = 1'b1;
            ctl.pc_source = bcond ? PC_SRC_BRANCH : PC_SRC_PLUS4;
            state_next    = S_IF;
          end
          OPC_JAL: begin
            ctl.alu_src_a = ALU_A_PC;
            ctl.alu_src_b = ALU_B_IMM;
            ctl.alu_op    = ALU_OP_ADD;
          end
          OPC_JALR: begin
            ctl.alu_src_a = ALU_A_RS1;
            ctl.alu_src_b = ALU_B_IMM;
            ctl.alu_op    = ALU_OP_ADD;
          end
          default: state_next = S_IF;
        endcase
      end
      S_MEM: begin
        ctl.i_or_d    = 1'b1;
        ctl.mem_read  = (opcode == OPC_LOAD);
        ctl.mem_write = (opcode == OPC_STORE);
        if (mem_ready) begin
          if (opcode == OPC_LOAD) begin
            state_next = S_WB;
          end else begin
            ctl.pc_write  = (opcode == OPC_STORE);
            ctl.pc_source = PC_SRC_PLUS4;
            state_next    = S_IF;
          end
        end
      end
      S_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.pc_write   = 1'b1;
        ctl.mem_to_reg = (opcode == OPC_LOAD);
        if (opcode == OPC_JAL || opcode == OPC_JALR) begin
          ctl.pc_to_reg = 1'b1;
          ctl.pc_source = PC_SRC_ALU;
        end else begin
          ctl.pc_source = PC_SRC_PLUS4;
        end
        state_next = S_IF;
      end
      S_HALT: ctl.halted = 1'b1;
      default: state_next = S_IF;
    endcase
  end

  // Reset also silences the outputs combinationally, so an in-flight access drops immediately.
  assign ctl_out = reset ? ctl : '0;

  assign mem_read   = ctl_out.mem_read;
  assign mem_write  = ctl_out.mem_write;
  assign i_or_d     = ctl_out.i_or_d;
  assign ir_write   = ctl_out.ir_write;
  assign reg_write  = ctl_out.reg_write;
  assign mem_to_reg = ctl_out.mem_to_reg;
  assign pc_to_reg  = ctl_out.pc_to_reg;
  assign alu_src_a  = ctl_out.alu_src_a;
  assign alu_src_b  = ctl_out.alu_src_b;
  assign alu_op     = ctl_out.alu_op;
  assign pc_write   = ctl_out.pc_write;
  assign pc_source  = ctl_out.pc_source;
  assign is_ecall   = ctl_out.is_ecall;
  assign halted     = ctl_out.halted;

  // Every PC update marks one retired instruction; HALT never writes the PC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                retired_cnt <= '0;
    else if (ctl_out.pc_write) retired_cnt <= retired_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: per-cycle expected control words are
// queued as stimulus is driven and compared against the DUT mid low-phase.
module tb_multicycle_control_fsm;

  localparam logic [6:0] R_OP   = 7'b0110011;
  localparam logic [6:0] I_OP   = 7'b0010011;
  localparam logic [6:0] LD_OP  = 7'b0000011;
  localparam logic [6:0] ST_OP  = 7'b0100011;
  localparam logic [6:0] BR_OP  = 7'b1100011;
  localparam logic [6:0] JAL_OP = 7'b1101111;
  localparam logic [6:0] JR_OP  = 7'b1100111;
  localparam logic [6:0] SYS_OP = 7'b1110011;
  localparam logic [6:0] LUI_OP = 7'b0110111;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [6:0]  opcode = '0;
  logic [31:0] rf17 = '0;
  logic        bcond = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_read, mem_write, i_or_d, ir_write, reg_write, mem_to_reg, pc_to_reg;
  logic        alu_src_a, pc_write, is_ecall, halted;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [31:0] retired_cnt;

  multicycle_control_fsm #(.CNT_W(32), .HALT_CODE(32'd10)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .rf17(rf17), .bcond(bcond),
    .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
    .ir_write(ir_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .pc_to_reg(pc_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_write(pc_write), .pc_source(pc_source), .is_ecall(is_ecall), .halted(halted),
    .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_read, mem_write, i_or_d, ir_write, reg_write, mem_to_reg, pc_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b, alu_op;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       is_ecall, halted;
  } exp_ctl_t;

  typedef struct {
    string       tag;
    exp_ctl_t    ctl;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_cnt = '0;

  function automatic exp_ctl_t observed();
    exp_ctl_t o;
    o = {mem_read, mem_write, i_or_d, ir_write, reg_write, mem_to_reg, pc_to_reg,
         alu_src_a, alu_src_b, alu_op, pc_write, pc_source, is_ecall, halted};
    return o;
  endfunction

  // One clock cycle: entered at a falling edge, returns at the next falling edge.
  task automatic cyc(input string tag, input logic [6:0] op, input logic [31:0] r17,
                     input logic bc, input logic rdy, input exp_ctl_t e);
    exp_t     x;
    exp_ctl_t o;
    opcode = op; rf17 = r17; bcond = bc; mem_ready = rdy;
    x.tag = tag; x.ctl = e; x.cnt = model_cnt;
    sb.push_back(x);
    if (e.pc_write) model_cnt = model_cnt + 32'd1;
    #2;
    x = sb.pop_front();
    o = observed();
    checks++;
    if (o !== x.ctl) begin
      errors++;
      $display("FAIL %s: control word got %h expected %h", x.tag, o, x.ctl);
    end
    checks++;
    if (retired_cnt !== x.cnt) begin
      errors++;
      $display("FAIL %s: retired_cnt got %0d expected %0d", x.tag, retired_cnt, x.cnt);
    end
    @(negedge clk);
  endtask

  task automatic run_instr(input string name, input logic [6:0] op, input logic [31:0] r17,
                           input logic bc, input int if_waits, input int mem_waits);
    exp_ctl_t e;
    logic     rdy;
    for (int i = 0; i < if_waits; i++) begin
      e = '0; e.mem_read = 1'b1;
      cyc({name, " IF wait"}, op, r17, ~bc, 1'b0, e);
    end
    e = '0; e.mem_read = 1'b1; e.ir_write = 1'b1;
    cyc({name, " IF"}, op, r17, ~bc, 1'b1, e);

    e = '0;
    if (op == SYS_OP) begin
      e.is_ecall = 1'b1;
      e.pc_write = (r17 != 32'd10);
      cyc({name, " ID"}, op, r17, ~bc, 1'b1, e);
      return;
    end
    if (!(op inside {R_OP, I_OP, LD_OP, ST_OP, BR_OP, JAL_OP, JR_OP})) begin
      e.pc_write = 1'b1;
      cyc({name, " ID"}, op, r17, ~bc, 1'b1, e);
      return;
    end
    cyc({name, " ID"}, op, r17, ~bc, 1'($urandom_range(0, 1)), e);

    e = '0;
    case (op)
      R_OP:         begin e.alu_src_a = 1'b1; e.alu_op = 2'd2; end
      I_OP:         begin e.alu_src_a = 1'b1; e.alu_src_b = 2'd1; e.alu_op = 2'd2; end
      LD_OP, ST_OP: begin e.alu_src_a = 1'b1; e.alu_src_b = 2'd1; end
      BR_OP: begin
        e.alu_src_a = 1'b1; e.alu_op = 2'd1; e.pc_write = 1'b1;
        e.pc_source = bc ? 2'd1 : 2'd0;
      end
      JAL_OP:       e.alu_src_b = 2'd1;
      JR_OP:        begin e.alu_src_a = 1'b1; e.alu_src_b = 2'd1; end
      default:      e = '0;
    endcase
    cyc({name, " EX"}, op, r17, bc, 1'($urandom_range(0, 1)), e);
    if (op == BR_OP) return;

    if (op == LD_OP || op == ST_OP) begin
      for (int i = 0; i <= mem_waits; i++) begin
        rdy = (i == mem_waits);
        e = '0; e.i_or_d = 1'b1;
        if (op == LD_OP) e.mem_read = 1'b1;
        else             e.mem_write = 1'b1;
        if (rdy && op == ST_OP) e.pc_write = 1'b1;
        cyc({name, " MEM"}, op, r17, ~bc, rdy, e);
      end
      if (op == ST_OP) return;
    end

    e = '0; e.reg_write = 1'b1; e.pc_write = 1'b1;
    if (op == LD_OP) e.mem_to_reg = 1'b1;
    if (op == JAL_OP || op == JR_OP) begin
      e.pc_to_reg = 1'b1; e.pc_source = 2'd2;
    end
    cyc({name, " WB"}, op, r17, ~bc, 1'($urandom_range(0, 1)), e);
  endtask

  task automatic test_reset();
    reset = 1'b0; model_cnt = '0;
    for (int i = 0; i < 3; i++) cyc("reset low", R_OP, 32'd0, 1'b1, 1'b1, '0);
    reset = 1'b1;
  endtask

  task automatic test_arith();
    run_instr("add", R_OP, 32'd0, 1'b0, 0, 0);
    run_instr("addi", I_OP, 32'd0, 1'b1, 0, 0);
  endtask

  task automatic test_load_wait();
    run_instr("lw wait3", LD_OP, 32'd0, 1'b0, 0, 3);
    run_instr("lw fetchwait", LD_OP, 32'd0, 1'b1, 2, 0);
  endtask

  task automatic test_branch();
    run_instr("beq taken", BR_OP, 32'd0, 1'b1, 0, 0);
    run_instr("beq not taken", BR_OP, 32'd0, 1'b0, 0, 0);
  endtask

  task automatic test_ecall_continue();
    run_instr("ecall rf17=5", SYS_OP, 32'd5, 1'b0, 0, 0);
    run_instr("lui nop", LUI_OP, 32'd10, 1'b0, 0, 0);
  endtask

  task automatic test_back_to_back();
    run_instr("jal", JAL_OP, 32'd0, 1'b0, 0, 0);
    run_instr("sw", ST_OP, 32'd0, 1'b1, 1, 2);
    run_instr("jalr", JR_OP, 32'd10, 1'b1, 0, 0);
    run_instr("sw zero wait", ST_OP, 32'd0, 1'b0, 0, 0);
    run_instr("add tail", R_OP, 32'd0, 1'b1, 0, 0);
  endtask

  task automatic test_halt();
    exp_ctl_t e;
    run_instr("ecall halt", SYS_OP, 32'd10, 1'b0, 0, 0);
    e = '0; e.halted = 1'b1;
    for (int i = 0; i < 20; i++)
      cyc("halted", (i % 2 == 0) ? R_OP : SYS_OP, 32'd5, 1'(i), 1'b1, e);
  endtask

  task automatic test_jalr_after_reset();
    reset = 1'b0; model_cnt = '0;
    for (int i = 0; i < 2; i++) cyc("reset from halt", SYS_OP, 32'd10, 1'b0, 1'b1, '0);
    reset = 1'b1;
    run_instr("jalr post reset", JR_OP, 32'd0, 1'b0, 0, 0);
  endtask

  task automatic test_reset_mid_store();
    exp_ctl_t e;
    exp_ctl_t o;
    e = '0; e.mem_read = 1'b1; e.ir_write = 1'b1;
    cyc("abort IF", ST_OP, 32'd0, 1'b0, 1'b1, e);
    cyc("abort ID", ST_OP, 32'd0, 1'b0, 1'b1, '0);
    e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'd1;
    cyc("abort EX", ST_OP, 32'd0, 1'b0, 1'b0, e);
    e = '0; e.i_or_d = 1'b1; e.mem_write = 1'b1;
    cyc("abort MEM", ST_OP, 32'd0, 1'b0, 1'b0, e);
    #1;
    checks++;
    if (mem_write !== 1'b1) begin
      errors++;
      $display("FAIL abort pre-reset: mem_write got %b expected 1", mem_write);
    end
    #1;
    reset = 1'b0; model_cnt = '0;
    #1;
    o = observed();
    checks++;
    if (o !== '0) begin
      errors++;
      $display("FAIL abort in reset: control word got %h expected 0", o);
    end
    checks++;
    if (retired_cnt !== 32'd0) begin
      errors++;
      $display("FAIL abort in reset: retired_cnt got %0d expected 0", retired_cnt);
    end
    @(negedge clk);
    cyc("abort reset held", ST_OP, 32'd0, 1'b0, 1'b1, '0);
    reset = 1'b1;
    run_instr("add after abort", R_OP, 32'd0, 1'b0, 0, 0);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_arith();
    test_load_wait();
    test_branch();
    test_ecall_continue();
    test_back_to_back();
    test_halt();
    test_jalr_after_reset();
    test_reset_mid_store();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
